// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        DONE      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle (high) level.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (2 cycles of latency)
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Reset to 1 so the line looks idle while coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
// Deserialises rx into data and raises dr until the consumer pulses go low.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   rx         : serial line, idles high
//   go         : high arms the receiver; low acknowledges dr / aborts a byte
//   data       : received byte, valid while dr = 1
//   dr         : data ready
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 20_250_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 go,
    output logic [DATA_BITS-1:0] data,
    output logic                 dr
);

    localparam int unsigned BIT_TIME  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_TIME = BIT_TIME / 2;
    // Stop sample lands mid-way through the last stop bit.
    localparam int unsigned STOP_TIME = BIT_TIME * STOP_BITS;
    localparam int unsigned CNT_W     = $clog2(STOP_TIME) + 1;
    localparam int unsigned IX_W      = $clog2(DATA_BITS);

    logic                 rxs;
    rx_state_t            state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IX_W-1:0]      ix, ix_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 dr_d;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );
`else
    assign rxs = rx;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ix    <= '0;
            data  <= '0;
            dr    <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ix    <= ix_d;
            data  <= data_d;
            dr    <= dr_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ix_d    = ix;
        data_d  = data;
        dr_d    = dr;

        if (!go) begin
            // Acknowledge or abort: both land in IDLE with dr cleared.
            state_d = IDLE;
            cnt_d   = '0;
            dr_d    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    dr_d = 1'b0;
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end

                START: begin
                    if (cnt == CNT_W'(HALF_TIME - 1)) begin
                        cnt_d = '0;
                        if (!rxs) begin
                            state_d = DATA;
                            ix_d    = '0;
                        end else begin
                            state_d = IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_W'(BIT_TIME - 1)) begin
                        cnt_d  = '0;
                        data_d = {rxs, data[DATA_BITS-1:1]};
                        ix_d   = ix + IX_W'(1);
                        if (ix == IX_W'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == CNT_W'(STOP_TIME - 1)) begin
                        cnt_d = '0;
                        if (rxs) begin
                            state_d = DONE;
                            dr_d    = 1'b1;
                        end else begin
                            state_d = WAIT_HIGH;   // framing error
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // Hold dr and data until go drops.
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dr_d    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BIT_TIME = 10, HALF_TIME = 5.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned BIT = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       go;
    logic [7:0] data;
    logic       dr;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .go    (go),
        .data  (data),
        .dr    (dr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; leaves rx at the stop level on return (on a negedge).
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_dr(input string tag, input int max_cycles);
        int n = 0;
        while (dr !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dr), 32'd1);
    endtask

    // One-cycle go-low acknowledge; dr must be clear the cycle after.
    task automatic ack(input string tag);
        go = 1'b0;
        @(negedge clk);
        check(tag, 32'(dr), 32'd0);
        go = 1'b1;
        @(negedge clk);
    endtask

    logic seen_dr;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        go    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dr", 32'(dr), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0x55: dr rises exactly at t0+95.
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);              // t0
                repeat (94) @(posedge clk);
                #1 check("dr_before_t95", 32'(dr), 32'd0);
                @(posedge clk);
                #1 check("dr_at_t95", 32'(dr), 32'd1);
                check("data_55", 32'(data), 32'h55);
            end
        join
        rx = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold_dr", 32'(dr), 32'd1);
            check("hold_data", 32'(data), 32'h55);
        end
        ack("ack_55");

        // 0xA3 after acknowledge.
        send_frame(8'hA3, 1'b1);
        rx = 1'b1;
        wait_dr("dr_a3", 20);
        check("data_a3", 32'(data), 32'hA3);
        ack("ack_a3");

        // Start-bit glitch of 3 cycles.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch_dr", 32'(dr), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        wait_dr("dr_3c", 20);
        check("data_3c", 32'(data), 32'h3C);
        ack("ack_3c");

        // Framing error on 0xFF, line held low, then 0x12.
        send_frame(8'hFF, 1'b0);
        repeat (20) @(negedge clk);
        check("frame_err_dr", 32'(dr), 32'd0);
        check("frame_err_state", 32'(dut.state), 32'(WAIT_HIGH));
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_high_exit", 32'(dut.state), 32'(IDLE));
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        wait_dr("dr_12", 20);
        check("data_12", 32'(data), 32'h12);
        ack("ack_12");

        // Abort at bit 4 of 0x0F; go stays low through the rest of the frame.
        seen_dr = 1'b0;
        fork
            send_frame(8'h0F, 1'b1);
            begin
                repeat (BIT + 4 * BIT + 5) @(negedge clk);
                go = 1'b0;
            end
            begin
                repeat (BIT * 10) begin
                    @(negedge clk);
                    seen_dr = seen_dr | dr;
                end
            end
        join
        rx = 1'b1;
        go = 1'b1;
        repeat (20) begin
            @(negedge clk);
            seen_dr = seen_dr | dr;
        end
        check("abort_no_dr", 32'(seen_dr), 32'd0);
        check("abort_state", 32'(dut.state), 32'(IDLE));

        // Reset mid-byte of 0xA5, after several ones have been shifted in.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (BIT + 6 * BIT + 5) @(negedge clk);
                check("pre_reset_state", 32'(dut.state), 32'(DATA));
                rst_n = 1'b0;
                #1;
                check("mid_reset_dr", 32'(dr), 32'd0);
                check("mid_reset_data", 32'(data), 32'h00);
                check("mid_reset_state", 32'(dut.state), 32'(IDLE));
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_dr", 32'(dr), 32'd0);

        // Back-to-back 0x01 then 0x80 with no idle time.
        fork
            begin
                send_frame(8'h01, 1'b1);
                send_frame(8'h80, 1'b1);
                rx = 1'b1;
            end
            begin
                wait_dr("dr_b2b_0", 120);
                check("data_b2b_0", 32'(data), 32'h01);
                ack("ack_b2b_0");
                wait_dr("dr_b2b_1", 120);
                check("data_b2b_1", 32'(data), 32'h80);
                ack("ack_b2b_1");
            end
        join

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
